// File: rtl/attr_fifo_pkg.sv
// Shared constants and helpers for the attribute result FIFO.
// Default geometry, address-width derivation and drop-counter saturation value.
package attr_fifo_pkg;

  localparam int unsigned ATTR_DATA_WIDTH_DEF = 135;
  localparam int unsigned ATTR_DEPTH_DEF      = 16;
  localparam int unsigned DROP_CNT_WIDTH_DEF  = 32;

  // Saturation value of the default-width drop counter (all ones)
  localparam logic [DROP_CNT_WIDTH_DEF-1:0] DROP_CNT_SAT_DEF = '1;

  // Pointer width for a power-of-two depth; pointers wrap naturally
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Per-cycle FIFO operation, encoded as {push_accepted, pop}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/attr_fifo_ram.sv
// Simple dual-port storage for the attribute result FIFO.
// One synchronous write port, one asynchronous read port.
module attr_fifo_ram
  import attr_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = ATTR_DATA_WIDTH_DEF,
  parameter  int unsigned DEPTH      = ATTR_DEPTH_DEF,
  localparam int unsigned AW         = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port
  // NOTE: the storage array is deliberately not reset; entries are only
  // observed once occupancy says they were written, and a reset on a wide
  // array would prevent it mapping onto RAM cells.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/attribute_result_fifo.sv
// attribute_result_fifo: FWFT buffer between the priority-mux stage and the
// statistics logic. Results arriving while full are dropped and recorded in a
// sticky overflow flag and a saturating drop counter.
// Build option: define ATTR_FIFO_DROP_CNT_EN to implement the drop counter;
// otherwise drop_count_o is tied to 0 (overflow_o is present in both builds).
module attribute_result_fifo
  import attr_fifo_pkg::*;
#(
  parameter  int unsigned ATTRIBUTE_DATA_WIDTH = ATTR_DATA_WIDTH_DEF,
  parameter  int unsigned DEPTH                = ATTR_DEPTH_DEF,
  parameter  int unsigned DROP_CNT_WIDTH       = DROP_CNT_WIDTH_DEF,
  localparam int unsigned AW                   = addr_width(DEPTH),
  localparam int unsigned OCC_W                = AW + 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            valid_i,
  input  logic [ATTRIBUTE_DATA_WIDTH-1:0] data_i,
  input  logic                            clear_i,
  output logic                            m_valid,
  output logic [ATTRIBUTE_DATA_WIDTH-1:0] m_data,
  input  logic                            m_ready,
  output logic [OCC_W-1:0]                occupancy_o,
  output logic                            overflow_o,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count_o
);

  logic [AW-1:0]                   wr_ptr;
  logic [AW-1:0]                   rd_ptr;
  logic [OCC_W-1:0]                occ;
  logic [ATTRIBUTE_DATA_WIDTH-1:0] ram_rdata;
  logic                            full;
  logic                            pop;
  logic                            accept;
  logic                            drop;
  fifo_op_e                        op;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign full   = (occ == OCC_W'(DEPTH));
  assign pop    = m_valid && m_ready;
  assign accept = valid_i && (!full || pop);
  assign drop   = valid_i && !accept;
  assign op     = fifo_op_e'({accept, pop});

  attr_fifo_ram #(
    .DATA_WIDTH (ATTRIBUTE_DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept && !clear_i),
    .waddr (wr_ptr),
    .wdata (data_i),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Pointers and occupancy; clear wins over any push or pop in its cycle
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case (op)
        OP_PUSH: occ <= occ + OCC_W'(1);
        OP_POP:  occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sticky overflow flag, set by the first dropped result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      overflow_o <= 1'b0;
    else if (clear_i) overflow_o <= 1'b0;
    else if (drop)    overflow_o <= 1'b1;
  end

`ifdef ATTR_FIFO_DROP_CNT_EN
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_SAT = '1;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  // Saturating count of dropped results
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                             drop_cnt <= '0;
    else if (clear_i)                        drop_cnt <= '0;
    else if (drop && (drop_cnt != DROP_SAT)) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
  end

  assign drop_count_o = drop_cnt;
`else
  assign drop_count_o = '0;
`endif

  // Outputs decode from registers only; payload forced to 0 while empty so
  // the reset value is defined even though storage is not reset
  assign m_valid     = (occ != '0);
  assign m_data      = m_valid ? ram_rdata : '0;
  assign occupancy_o = occ;

endmodule
